// File: rtl/vc_wrr_arbiter_pkg.sv
// Shared types and constants for the 4-VC weighted round-robin arbiter.
package vc_wrr_arbiter_pkg;

  localparam int VC_N   = 4;  // number of virtual channels
  localparam int VC_IW  = 2;  // width of a VC index
  localparam int WW_DEF = 4;  // default per-VC weight width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    HOLD  = 2'd2
  } arb_state_e;

  // Next VC index; the 2-bit add wraps 3 -> 0 naturally.
  function automatic logic [VC_IW-1:0] vc_inc(input logic [VC_IW-1:0] i);
    return i + 2'd1;
  endfunction

endpackage

// File: rtl/vc_wrr_arbiter_if.sv
// VC-FIFO / downstream-FIFO bundle seen by the arbiter.
interface vc_wrr_arbiter_if #(
  parameter int BW = 4,
  parameter int WW = vc_wrr_arbiter_pkg::WW_DEF
);
  localparam int N = vc_wrr_arbiter_pkg::VC_N;

  logic              arb_en;
  logic [N*WW-1:0]   wrr_weights;
  logic [N-1:0]      vc_empty;
  logic [N*BW-1:0]   vc_data;
  logic [N-1:0]      vc_rd;
  logic              down_almost_full;
  logic              down_wr;
  logic [BW-1:0]     down_data;
  logic [1:0]        active_vc;
  logic              busy;

  // Arbiter side
  modport master (
    input  arb_en, wrr_weights, vc_empty, vc_data, down_almost_full,
    output vc_rd, down_wr, down_data, active_vc, busy
  );

  // Environment side (VC FIFOs, downstream FIFO, control)
  modport slave (
    output arb_en, wrr_weights, vc_empty, vc_data, down_almost_full,
    input  vc_rd, down_wr, down_data, active_vc, busy
  );

endinterface

// File: rtl/vc_wrr_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit at or after start.
module vc_rr_pick
  import vc_wrr_arbiter_pkg::*;
(
  input  logic [VC_N-1:0]  req,
  input  logic [VC_IW-1:0] start,
  output logic [VC_IW-1:0] idx,
  output logic             vld
);

  // Scan offsets from far to near so the closest hit to start wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    for (int k = VC_N - 1; k >= 0; k--) begin
      if (req[VC_IW'(32'(start) + k)]) begin
        vld = 1'b1;
        idx = VC_IW'(32'(start) + k);
      end
    end
  end

endmodule

// File: rtl/vc_wrr_arbiter.sv
// Weighted round-robin arbiter draining 4 VC FIFOs into one downstream FIFO.
// Each grant reads up to weight[vc] words back to back, then rotates.
module vc_wrr_arbiter
  import vc_wrr_arbiter_pkg::*;
#(
  parameter int BW = 4,
  parameter int WW = WW_DEF
) (
  input  logic           clk,
  input  logic           reset_L,
  vc_wrr_arbiter_if.master bus
);

  // Per-VC views of the flat weight and data buses
  logic [VC_N-1:0][WW-1:0] wt;
  logic [VC_N-1:0][BW-1:0] dat;

  for (genvar g = 0; g < VC_N; g++) begin : g_vc
    assign wt[g]  = bus.wrr_weights[g*WW +: WW];
    assign dat[g] = bus.vc_data[g*BW +: BW];
  end

  arb_state_e       state;
  logic [VC_IW-1:0] grant_q;
  logic [VC_IW-1:0] last_grant;
  logic [WW-1:0]    credit;
  logic             down_wr_q;
  logic [BW-1:0]    down_data_q;
  logic             busy_q;

  logic [VC_IW-1:0] pick_idx;
  logic             pick_vld;
  logic [WW-1:0]    load_cred;
  logic             rd_ok;
  logic             last_rd;

  // Search always starts just past the last grant; on rotation last_grant
  // equals the VC being left, so a lone VC comes back to itself.
  vc_rr_pick u_pick (
    .req   (~bus.vc_empty),
    .start (vc_inc(last_grant)),
    .idx   (pick_idx),
    .vld   (pick_vld)
  );

  // Fresh credit for the candidate grant; weight 0 still buys one word.
  assign load_cred = (wt[pick_idx] == '0) ? WW'(1) : wt[pick_idx];

  // Read only when serving, enabled, downstream has room and the VC has data.
  assign rd_ok   = (state == SERVE) && bus.arb_en && !bus.down_almost_full &&
                   !bus.vc_empty[grant_q];
  assign last_rd = rd_ok && (credit == WW'(1));

  assign bus.vc_rd     = rd_ok ? (VC_N'(1) << grant_q) : '0;
  assign bus.down_wr   = down_wr_q;
  assign bus.down_data = down_data_q;
  assign bus.active_vc = grant_q;
  assign bus.busy      = busy_q;

  // Grant FSM, credit accounting and the one-cycle read-to-write stage
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state       <= IDLE;
      grant_q     <= '0;
      last_grant  <= VC_IW'(VC_N - 1);
      credit      <= '0;
      down_wr_q   <= 1'b0;
      down_data_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      down_wr_q <= rd_ok;
      if (rd_ok) down_data_q <= dat[grant_q];

      case (state)
        IDLE: begin
          if (bus.arb_en && pick_vld && !bus.down_almost_full) begin
            state      <= SERVE;
            busy_q     <= 1'b1;
            grant_q    <= pick_idx;
            last_grant <= pick_idx;
            credit     <= load_cred;
          end
        end

        SERVE: begin
          if (!bus.arb_en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            credit <= '0;
          end else if (bus.down_almost_full) begin
            state <= HOLD;
          end else if (bus.vc_empty[grant_q] || last_rd) begin
            // Rotate in place; the VC being read this cycle still shows
            // non-empty, so a lone VC is simply re-granted.
            if (pick_vld) begin
              grant_q    <= pick_idx;
              last_grant <= pick_idx;
              credit     <= load_cred;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
              credit <= '0;
            end
          end else begin
            credit <= credit - WW'(1);
          end
        end

        HOLD: begin
          if (!bus.arb_en) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            credit <= '0;
          end else if (!bus.down_almost_full) begin
            state <= SERVE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vc_wrr_arbiter.sv
// Directed + random bench for vc_wrr_arbiter with VC FIFO and downstream models.
module tb_vc_wrr_arbiter;

  localparam int BW   = 4;
  localparam int WW   = 4;
  localparam int LOGN = 256;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_wrr_arbiter_if #(.BW(BW), .WW(WW)) bus ();

  vc_wrr_arbiter #(.BW(BW), .WW(WW)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int tests = 0, failed = 0;

  // Environment model state
  int   cnt[4];
  int   taken[4];
  int   occ;
  int   ld_cnt[4];
  bit   ld = 1'b0;
  bit   rnd_mode = 1'b0;
  bit   afull_force = 1'b0;
  int   add_vc = -1;
  bit   drain = 1'b0;

  // Monitor state
  int        viol = 0;
  int        nlog = 0;
  bit        prev_rd = 1'b0;
  logic [3:0] logq[LOGN];
  int        base_log, base_viol;

  // VC FIFO contents are counters; word k of VCv reads as {v, k[1:0]}.
  always_comb begin
    for (int v = 0; v < 4; v++) begin
      bus.vc_empty[v]        = (cnt[v] == 0);
      bus.vc_data[v*BW +: BW] = {2'(v), 2'(taken[v])};
    end
    bus.down_almost_full = rnd_mode ? (occ >= 3) : afull_force;
  end

  always @(posedge clk) begin
    if (ld) begin
      for (int v = 0; v < 4; v++) begin
        cnt[v]   <= ld_cnt[v];
        taken[v] <= 0;
      end
      occ <= 0;
    end else begin
      for (int v = 0; v < 4; v++) begin
        cnt[v] <= cnt[v] - (bus.vc_rd[v] ? 1 : 0) + ((add_vc == v) ? 1 : 0);
        if (bus.vc_rd[v]) taken[v] <= taken[v] + 1;
      end
      occ <= occ + (bus.down_wr ? 1 : 0) - ((drain && occ > 0) ? 1 : 0);
    end
  end

  // Protocol watch: legal strobes, 1-cycle read-to-write, no overflow; logs writes.
  always @(negedge clk) begin
    if (!reset_L) begin
      prev_rd = 1'b0;
    end else begin
      if ((bus.vc_rd & bus.vc_empty) != 4'b0) viol++;
      if (!$onehot0(bus.vc_rd)) viol++;
      if (bus.down_wr != prev_rd) viol++;
      if (rnd_mode && occ > 4) viol++;
      if (bus.down_wr) begin
        if (nlog < LOGN) logq[nlog] = bus.down_data;
        nlog++;
      end
      prev_rd = |bus.vc_rd;
    end
  end

  typedef struct {
    logic [15:0] wts;
    int          n0, n1, n2, n3;
    string       seq;   // expected write order, one VC digit per write
  } vec_t;

  vec_t vt[4];

  function automatic vec_t mk(input logic [15:0] w, input int a, input int b,
                              input int c, input int d, input string s);
    vec_t r;
    r.wts = w; r.n0 = a; r.n1 = b; r.n2 = c; r.n3 = d; r.seq = s;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_vec(input logic [15:0] w, input int c0, input int c1,
                           input int c2, input int c3, input bit do_rst);
    tick();
    bus.arb_en = 1'b0;
    afull_force = 1'b0;
    bus.wrr_weights = w;
    ld_cnt[0] = c0; ld_cnt[1] = c1; ld_cnt[2] = c2; ld_cnt[3] = c3;
    ld = 1'b1;
    if (do_rst) reset_L = 1'b0;
    tick();
    ld = 1'b0;
    reset_L = 1'b1;
    base_log = nlog;
    base_viol = viol;
    bus.arb_en = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    bit seen, done;
    k = 0; seen = 1'b0; done = 1'b0;
    while (!done && k < 400) begin
      tick();
      if (bus.busy) seen = 1'b1;
      else if (seen) done = 1'b1;
      k++;
    end
    chk({nm, " reaches idle"}, int'(done), 1);
    repeat (3) tick();
    bus.arb_en = 1'b0;
  endtask

  task automatic check_seq(input string nm, input string seq);
    int k[4];
    int got;
    k = '{0, 0, 0, 0};
    got = nlog - base_log;
    chk({nm, " write count"}, got, seq.len());
    for (int j = 0; j < seq.len() && j < got; j++) begin
      int v;
      logic [3:0] e;
      v = int'(seq[j]) - 48;
      e = {2'(v), 2'(k[v])};
      k[v]++;
      chk($sformatf("%s write%0d", nm, j), int'(logq[base_log + j]), int'(e));
    end
    chk({nm, " protocol"}, viol - base_viol, 0);
  endtask

  initial begin
    reset_L = 1'b0;
    bus.arb_en = 1'b0;
    bus.wrr_weights = '0;
    ld_cnt = '{0, 0, 0, 0};
    ld = 1'b1;

    vt[0] = mk(16'h1111, 3, 3, 3, 3, "012301230123");
    vt[1] = mk(16'h0013, 6, 6, 0, 0, "000100011111");
    vt[2] = mk(16'h02F0, 0, 17, 2, 0, "1111111111111112211");
    vt[3] = mk(16'h2222, 1, 3, 0, 2, "011331");

    // Reset state
    repeat (2) tick();
    chk("rst vc_rd", int'(bus.vc_rd), 0);
    chk("rst down_wr", int'(bus.down_wr), 0);
    chk("rst down_data", int'(bus.down_data), 0);
    chk("rst active_vc", int'(bus.active_vc), 0);
    chk("rst busy", int'(bus.busy), 0);
    ld = 1'b0;
    reset_L = 1'b1;

    // Table-driven weight/occupancy patterns
    for (int i = 0; i < 4; i++) begin
      start_vec(vt[i].wts, vt[i].n0, vt[i].n1, vt[i].n2, vt[i].n3, 1'b1);
      wait_idle($sformatf("vec%0d", i));
      check_seq($sformatf("vec%0d", i), vt[i].seq);
    end

    // Lone VC3 at weight 0, then wrap to VC0 without a reset in between
    start_vec(16'h0000, 0, 0, 0, 2, 1'b1);
    wait_idle("lone3");
    check_seq("lone3", "33");
    start_vec(16'h0000, 1, 0, 0, 0, 1'b0);
    tick();
    chk("wrap active_vc", int'(bus.active_vc), 0);
    wait_idle("wrap0");
    check_seq("wrap0", "0");

    // Backpressure with two credits left on VC2
    start_vec(16'h1400, 0, 0, 8, 1, 1'b1);
    repeat (3) tick();
    afull_force = 1'b1;
    #1;
    chk("afull vc_rd", int'(bus.vc_rd), 0);
    for (int h = 0; h < 3; h++) begin
      tick();
      chk($sformatf("hold%0d vc_rd", h), int'(bus.vc_rd), 0);
      chk($sformatf("hold%0d active_vc", h), int'(bus.active_vc), 2);
      chk($sformatf("hold%0d busy", h), int'(bus.busy), 1);
    end
    afull_force = 1'b0;
    wait_idle("hold");
    check_seq("hold", "222232222");

    // Reset pulsed mid-transfer
    start_vec(16'h1111, 2, 2, 2, 2, 1'b1);
    repeat (3) tick();
    #1 reset_L = 1'b0;
    #1;
    chk("midrst vc_rd", int'(bus.vc_rd), 0);
    chk("midrst down_wr", int'(bus.down_wr), 0);
    chk("midrst down_data", int'(bus.down_data), 0);
    chk("midrst active_vc", int'(bus.active_vc), 0);
    chk("midrst busy", int'(bus.busy), 0);
    repeat (2) tick();
    reset_L = 1'b1;
    base_log = nlog;
    base_viol = viol;
    tick();
    chk("postrst active_vc", int'(bus.active_vc), 0);
    chk("postrst vc_rd", int'(bus.vc_rd), 1);
    chk("postrst down_wr", int'(bus.down_wr), 0);
    wait_idle("postrst");
    chk("postrst write count", nlog - base_log, 6);
    chk("postrst protocol", viol - base_viol, 0);

    // Random traffic with a live downstream FIFO
    rnd_mode = 1'b1;
    start_vec(16'($urandom), 0, 0, 0, 0, 1'b1);
    for (int c = 0; c < 10000; c++) begin
      tick();
      add_vc = ($urandom_range(0, 9) < 4) ? int'($urandom_range(0, 3)) : -1;
      drain = ($urandom_range(0, 1) == 1);
      bus.arb_en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 499) == 0) bus.wrr_weights = 16'($urandom);
    end
    add_vc = -1;
    bus.arb_en = 1'b0;
    repeat (4) tick();
    chk("random protocol", viol - base_viol, 0);
    chk("random progress", int'((nlog - base_log) > 500), 1);
    rnd_mode = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
